// File: rtl/wb_burst_master_if.sv
// Wishbone B3 bus bundle between the burst master and the SDRAM controller's slave port.
interface wb_burst_master_if #(
    parameter int APP_AW = 26,
    parameter int dw     = 32
);
    logic              wb_cyc;
    logic              wb_stb;
    logic              wb_we;
    logic [APP_AW-1:0] wb_addr;
    logic [dw-1:0]     wb_dati;
    logic [dw/8-1:0]   wb_sel;
    logic [2:0]        wb_cti;
    logic              wb_ack;
    logic [dw-1:0]     wb_dato;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_addr, wb_dati, wb_sel, wb_cti,
        input  wb_ack, wb_dato
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_addr, wb_dati, wb_sel, wb_cti,
        output wb_ack, wb_dato
    );
endinterface

// File: rtl/wb_burst_master.sv
// Turns single commands into incrementing Wishbone bursts, with a 1-entry write
// holding register, registered read-data stream and a per-beat ack timeout.
//
// state  | meaning
// IDLE   | ready for a command; write data may be pre-loaded into the holding register
// BURST  | wb_cyc high; beats issued until the count runs out or the ack timer expires
// FINISH | bus released; done pulses on the second cycle, then back to IDLE
module wb_burst_master #(
    parameter int APP_AW  = 26,
    parameter int dw      = 32,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              wb_clk,
    input  logic              wb_resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [APP_AW-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [dw/8-1:0]   cmd_sel,
    input  logic              wdat_valid,
    output logic              wdat_ready,
    input  logic [dw-1:0]     wdat,
    output logic              rdat_valid,
    output logic [dw-1:0]     rdat,
    output logic              rdat_last,
    output logic              done,
    output logic              err,
    wb_burst_master_if.master wb
);
    localparam int SW = dw / 8;
    localparam int CW = LEN_W + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW-1:0] TWO = CW'(2);

    typedef enum logic [1:0] {IDLE, BURST, FINISH} state_t;

    state_t            state_q, state_nx;
    logic              fin_q, fin_nx;
    logic              cyc_q, cyc_nx;
    logic              stb_q, stb_nx;
    logic              we_q, we_nx;
    logic [APP_AW-1:0] addr_q, addr_nx;
    logic [SW-1:0]     sel_q, sel_nx;
    logic [2:0]        cti_q, cti_nx;
    logic [CW-1:0]     rem_q, rem_nx;
    logic [TW-1:0]     to_q, to_nx;
    logic              full_q, full_nx;
    logic [dw-1:0]     wreg_q;
    logic [dw-1:0]     rdat_q, rdat_nx;
    logic              rvalid_q, rvalid_nx;
    logic              rlast_q, rlast_nx;
    logic              done_q, done_nx;
    logic              err_q, err_nx;

    logic              beat;
    logic              pop;
    logic              push;
    logic [CW-1:0]     len_ld;

    assign beat   = (state_q == BURST) && stb_q && wb.wb_ack;
    assign pop    = beat && we_q;
    assign push   = wdat_valid && wdat_ready;
    assign len_ld = (cmd_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, cmd_len};

    // The register can refill in the same cycle its current word is acked.
    assign wdat_ready = wb_resetn && (!full_q || pop);
    assign full_nx    = push || (full_q && !pop);
    assign cmd_ready  = (state_q == IDLE);

    always_comb begin
        state_nx  = state_q;
        fin_nx    = 1'b0;
        cyc_nx    = cyc_q;
        stb_nx    = stb_q;
        we_nx     = we_q;
        addr_nx   = addr_q;
        sel_nx    = sel_q;
        cti_nx    = cti_q;
        rem_nx    = rem_q;
        to_nx     = to_q;
        rdat_nx   = rdat_q;
        rvalid_nx = 1'b0;
        rlast_nx  = 1'b0;
        done_nx   = 1'b0;
        err_nx    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_nx = BURST;
                    cyc_nx   = 1'b1;
                    stb_nx   = !cmd_we || full_nx;
                    we_nx    = cmd_we;
                    addr_nx  = cmd_addr;
                    sel_nx   = cmd_sel;
                    rem_nx   = len_ld;
                    cti_nx   = (len_ld == ONE) ? 3'b111 : 3'b010;
                    to_nx    = TO_LOAD;
                end
            end
            BURST: begin
                if (beat) begin
                    rem_nx    = rem_q - ONE;
                    addr_nx   = addr_q + APP_AW'(SW);
                    to_nx     = TO_LOAD;
                    rvalid_nx = !we_q;
                    rlast_nx  = !we_q && (rem_q == ONE);
                    if (!we_q) rdat_nx = wb.wb_dato;
                    if (rem_q == ONE) begin
                        state_nx = FINISH;
                        cyc_nx   = 1'b0;
                        stb_nx   = 1'b0;
                        cti_nx   = 3'b000;
                    end else begin
                        stb_nx = !we_q || full_nx;
                        cti_nx = (rem_q == TWO) ? 3'b111 : 3'b010;
                    end
                end else if (stb_q) begin
                    if (to_q == '0) begin
                        state_nx = IDLE;
                        cyc_nx   = 1'b0;
                        stb_nx   = 1'b0;
                        cti_nx   = 3'b000;
                        err_nx   = 1'b1;
                    end else begin
                        to_nx = to_q - 1'b1;
                    end
                end else begin
                    // write wait state: strobe as soon as a word is held
                    stb_nx = full_nx;
                end
            end
            FINISH: begin
                if (!fin_q) begin
                    fin_nx  = 1'b1;
                    done_nx = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_resetn) begin
            state_q <= IDLE;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_nx;
            fin_q   <= fin_nx;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_resetn) begin
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            sel_q    <= '0;
            cti_q    <= 3'b000;
            rem_q    <= '0;
            to_q     <= '0;
            full_q   <= 1'b0;
            wreg_q   <= '0;
            rdat_q   <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cyc_q    <= cyc_nx;
            stb_q    <= stb_nx;
            we_q     <= we_nx;
            addr_q   <= addr_nx;
            sel_q    <= sel_nx;
            cti_q    <= cti_nx;
            rem_q    <= rem_nx;
            to_q     <= to_nx;
            full_q   <= full_nx;
            if (push) wreg_q <= wdat;
            rdat_q   <= rdat_nx;
            rvalid_q <= rvalid_nx;
            rlast_q  <= rlast_nx;
            done_q   <= done_nx;
            err_q    <= err_nx;
        end
    end

    assign wb.wb_cyc  = cyc_q;
    assign wb.wb_stb  = stb_q;
    assign wb.wb_we   = we_q;
    assign wb.wb_addr = addr_q;
    assign wb.wb_dati = wreg_q;
    assign wb.wb_sel  = sel_q;
    assign wb.wb_cti  = cti_q;

    assign rdat_valid = rvalid_q;
    assign rdat       = rdat_q;
    assign rdat_last  = rlast_q;
    assign done       = done_q;
    assign err        = err_q;
endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: reads, late/streamed writes, address wrap,
// ack timeout and mid-burst reset, against a small configurable Wishbone slave.
module tb_wb_burst_master;
    logic        clk;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [25:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic [3:0]  cmd_sel;
    logic        wdat_valid;
    logic        wdat_ready;
    logic [31:0] wdat;
    logic        rdat_valid;
    logic [31:0] rdat;
    logic        rdat_last;
    logic        done;
    logic        err;

    wb_burst_master_if #(.APP_AW(26), .dw(32)) bus ();

    wb_burst_master #(.APP_AW(26), .dw(32), .LEN_W(4), .TIMEOUT(16)) dut (
        .wb_clk     (clk),
        .wb_resetn  (resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_sel    (cmd_sel),
        .wdat_valid (wdat_valid),
        .wdat_ready (wdat_ready),
        .wdat       (wdat),
        .rdat_valid (rdat_valid),
        .rdat       (rdat),
        .rdat_last  (rdat_last),
        .done       (done),
        .err        (err),
        .wb         (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // slave: 0 = never ack, 1 = zero-wait, 2 = two wait states per beat
    logic [1:0] ack_mode;
    logic [1:0] wcnt = 2'd0;
    always @(posedge clk) begin
        if (bus.wb_stb && !bus.wb_ack) wcnt <= wcnt + 2'd1;
        else                           wcnt <= 2'd0;
    end
    assign bus.wb_ack  = (ack_mode == 2'd1) ? bus.wb_stb :
                         (ack_mode == 2'd2) ? (bus.wb_stb && wcnt == 2'd2) : 1'b0;
    assign bus.wb_dato = 32'hDEAD_0000 ^ {6'd0, bus.wb_addr};

    logic [25:0] ba_q[$];
    logic [2:0]  bc_q[$];
    logic [31:0] bd_q[$];
    logic [3:0]  bs_q[$];
    logic        bw_q[$];
    logic [31:0] rd_q[$];
    logic        rl_q[$];
    int stb_cycles = 0, wait_cycles = 0, done_cnt = 0, err_cnt = 0;
    int stb_rise = 0, cyc_fall = 0, last_ack = 0, done_cyc = 0, err_cyc = 0;
    bit done_rdy, prev_stb, prev_cyc;

    always @(negedge clk) begin
        if (bus.wb_stb) stb_cycles++;
        if (bus.wb_cyc && !bus.wb_stb) wait_cycles++;
        if (bus.wb_stb && !prev_stb) stb_rise = cyc_n;
        if (!bus.wb_cyc && prev_cyc) cyc_fall = cyc_n;
        if (bus.wb_stb && bus.wb_ack) begin
            ba_q.push_back(bus.wb_addr);
            bc_q.push_back(bus.wb_cti);
            bd_q.push_back(bus.wb_dati);
            bs_q.push_back(bus.wb_sel);
            bw_q.push_back(bus.wb_we);
            last_ack = cyc_n;
        end
        if (rdat_valid) begin
            rd_q.push_back(rdat);
            rl_q.push_back(rdat_last);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc_n;
            done_rdy = cmd_ready;
        end
        if (err) begin
            err_cnt++;
            err_cyc = cyc_n;
        end
        prev_stb = bus.wb_stb;
        prev_cyc = bus.wb_cyc;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [25:0] a, input logic [3:0] l,
                         input logic [3:0] s, output int acc);
        cmd_we    = we;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_sel   = s;
        cmd_valid = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        @(posedge clk);
        #1;
        acc       = cyc_n;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_end(input int d0, input int e0);
        for (int n = 0; n < 400; n++) begin
            if (done_cnt > d0 || err_cnt > e0) break;
            step();
        end
    endtask

    initial begin
        int a, b0, r0, s0, w0, d0, e0, got_words;
        resetn     = 1'b0;
        cmd_valid  = 1'b0;
        cmd_we     = 1'b0;
        cmd_addr   = '0;
        cmd_len    = '0;
        cmd_sel    = '0;
        wdat_valid = 1'b0;
        wdat       = '0;
        ack_mode   = 2'd1;
        repeat (3) step();

        // reset values
        check("rst_cyc_stb_we", 64'({bus.wb_cyc, bus.wb_stb, bus.wb_we}), 64'(0));
        check("rst_addr", 64'(bus.wb_addr), 64'(0));
        check("rst_dati_sel", 64'({bus.wb_dati, bus.wb_sel}), 64'(0));
        check("rst_cti", 64'(bus.wb_cti), 64'(0));
        check("rst_streams", 64'({wdat_ready, rdat_valid, rdat_last, done, err}), 64'(0));
        check("rst_rdat", 64'(rdat), 64'(0));
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        resetn = 1'b1;
        step();
        check("post_rst_wdat_ready", 64'(wdat_ready), 64'(1));

        // read 0x100 x4, zero-wait
        b0 = ba_q.size(); r0 = rd_q.size(); s0 = stb_cycles; d0 = done_cnt; e0 = err_cnt;
        issue(1'b0, 26'h100, 4'd4, 4'hF, a);
        wait_end(d0, e0);
        check("t1_done", 64'(done_cnt - d0), 64'(1));
        check("t1_beats", 64'(ba_q.size() - b0), 64'(4));
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t1_addr%0d", k), 64'(ba_q[b0+k]), 64'(32'h100 + 4 * k));
            check($sformatf("t1_cti%0d", k), 64'(bc_q[b0+k]), (k == 3) ? 64'(7) : 64'(2));
            check($sformatf("t1_rdat%0d", k), 64'(rd_q[r0+k]), 64'(32'hDEAD_0100 + 4 * k));
            check($sformatf("t1_rlast%0d", k), 64'(rl_q[r0+k]), (k == 3) ? 64'(1) : 64'(0));
        end
        check("t1_rvalid_cnt", 64'(rd_q.size() - r0), 64'(4));
        check("t1_stb_start", 64'(stb_rise), 64'(a));
        check("t1_stb_cycles", 64'(stb_cycles - s0), 64'(4));
        check("t1_cyc_fall", 64'(cyc_fall - last_ack), 64'(1));
        check("t1_done_lat", 64'(done_cyc - last_ack), 64'(2));
        check("t1_rdy_in_done", 64'(done_rdy), 64'(0));
        check("t1_rdy_after", 64'(cmd_ready), 64'(1));
        check("t1_no_err", 64'(err_cnt - e0), 64'(0));

        // write x1, data 3 cycles late
        b0 = ba_q.size(); r0 = rd_q.size(); s0 = stb_cycles; w0 = wait_cycles;
        d0 = done_cnt; e0 = err_cnt;
        issue(1'b1, 26'h40, 4'd1, 4'b0011, a);
        step();
        step();
        wdat_valid = 1'b1;
        wdat       = 32'hA5A5_0001;
        step();
        wdat_valid = 1'b0;
        wait_end(d0, e0);
        check("t2_done", 64'(done_cnt - d0), 64'(1));
        check("t2_wait_cycles", 64'(wait_cycles - w0), 64'(3));
        check("t2_stb_start", 64'(stb_rise), 64'(a + 3));
        check("t2_beats", 64'(ba_q.size() - b0), 64'(1));
        check("t2_cti", 64'(bc_q[b0]), 64'(7));
        check("t2_sel", 64'(bs_q[b0]), 64'(4'b0011));
        check("t2_dati", 64'(bd_q[b0]), 64'(32'hA5A5_0001));
        check("t2_we", 64'(bw_q[b0]), 64'(1));
        check("t2_no_rdat", 64'(rd_q.size() - r0), 64'(0));

        // write x16 (len 0), two wait states, data every other cycle
        ack_mode = 2'd2;
        b0 = ba_q.size(); s0 = stb_cycles; d0 = done_cnt; e0 = err_cnt;
        issue(1'b1, 26'h200, 4'd0, 4'hF, a);
        got_words = 0;
        for (int n = 0; n < 400 && got_words < 16; n++) begin
            if (n % 2 == 0) begin
                wdat_valid = 1'b1;
                wdat       = 32'h1000_0000 + got_words;
                @(negedge clk);
                if (wdat_ready) got_words++;
            end else begin
                wdat_valid = 1'b0;
            end
            step();
        end
        wdat_valid = 1'b0;
        wait_end(d0, e0);
        check("t3_done", 64'(done_cnt - d0), 64'(1));
        check("t3_beats", 64'(ba_q.size() - b0), 64'(16));
        for (int k = 0; k < 16; k++)
            check($sformatf("t3_dat%0d", k), 64'(bd_q[b0+k]), 64'(32'h1000_0000 + k));
        check("t3_addr_last", 64'(ba_q[b0+15]), 64'(26'h23C));
        check("t3_cti_14_15", 64'({bc_q[b0+14], bc_q[b0+15]}), 64'({3'b010, 3'b111}));
        check("t3_stb_cycles", 64'(stb_cycles - s0), 64'(48));

        // read across the top of the address space
        ack_mode = 2'd1;
        b0 = ba_q.size(); d0 = done_cnt; e0 = err_cnt;
        issue(1'b0, 26'h3FF_FFF8, 4'd4, 4'hF, a);
        wait_end(d0, e0);
        check("t4_done", 64'(done_cnt - d0), 64'(1));
        check("t4_addr0", 64'(ba_q[b0]), 64'(26'h3FF_FFF8));
        check("t4_addr1", 64'(ba_q[b0+1]), 64'(26'h3FF_FFFC));
        check("t4_addr2", 64'(ba_q[b0+2]), 64'(26'h000_0000));
        check("t4_addr3", 64'(ba_q[b0+3]), 64'(26'h000_0004));

        // slave never acks: timeout after 16 strobe cycles
        ack_mode = 2'd0;
        r0 = rd_q.size(); s0 = stb_cycles; d0 = done_cnt; e0 = err_cnt;
        issue(1'b0, 26'h40, 4'd2, 4'hF, a);
        wait_end(d0, e0);
        step();
        step();
        check("t5_err_pulses", 64'(err_cnt - e0), 64'(1));
        check("t5_stb_cycles", 64'(stb_cycles - s0), 64'(16));
        check("t5_err_time", 64'(err_cyc - stb_rise), 64'(16));
        check("t5_cyc_fall", 64'(cyc_fall), 64'(err_cyc));
        check("t5_no_done", 64'(done_cnt - d0), 64'(0));
        check("t5_no_rdat", 64'(rd_q.size() - r0), 64'(0));
        ack_mode = 2'd1;
        b0 = ba_q.size(); d0 = done_cnt; e0 = err_cnt;
        issue(1'b0, 26'h80, 4'd1, 4'hF, a);
        wait_end(d0, e0);
        check("t5_recover_done", 64'(done_cnt - d0), 64'(1));
        check("t5_recover_beat", 64'({ba_q[b0], bc_q[b0]}), 64'({26'h80, 3'b111}));

        // reset during the 2nd beat of an 8-beat read
        issue(1'b0, 26'h300, 4'd8, 4'hF, a);
        step();
        resetn = 1'b0;
        step();
        check("t6_bus_idle", 64'({bus.wb_cyc, bus.wb_stb}), 64'(0));
        check("t6_outs_quiet", 64'({rdat_valid, done, err}), 64'(0));
        r0 = rd_q.size(); s0 = stb_cycles; d0 = done_cnt; e0 = err_cnt;
        resetn = 1'b1;
        repeat (6) step();
        check("t6_no_events", 64'({rd_q.size() - r0, done_cnt - d0}), 64'(0));
        check("t6_no_err", 64'(err_cnt - e0), 64'(0));
        check("t6_no_stb", 64'(stb_cycles - s0), 64'(0));
        check("t6_cmd_ready", 64'(cmd_ready), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_burst_master.md
# wb_burst_master

Wishbone B3 bus master that turns single command requests (address, beat count, direction) into incrementing-burst Wishbone cycles on the `wb_*` bus feeding the SDRAM controller's Wishbone slave port. It sits directly upstream of the controller. Write data streams in through a valid/ready port, and read data streams out with a last-beat marker. A per-beat ack timeout guarantees the bus is always released.

## Interface
- `APP_AW`, default 26: Wishbone byte-address width.
- `dw`, default 32: data width. `dw/8` byte lanes.
- `LEN_W`, default 4: beat-count width. A `cmd_len` of 0 means 2^LEN_W beats.
- `TIMEOUT`, default 1024: cycles allowed without `wb_ack` while `wb_stb` is high.

Ports:
- `wb_clk` in 1: the single clock. All logic is on its rising edge.
- `wb_resetn` in 1: reset, synchronous, active-low.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_we` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in APP_AW: start byte address, aligned to `dw/8`.
- `cmd_len` in LEN_W: beat count.
- `cmd_sel` in dw/8: byte enables, applied to every beat.
- `wdat_valid` in 1 / `wdat_ready` out 1 / `wdat` in dw: write-data stream.
- `rdat_valid` out 1 / `rdat` out dw / `rdat_last` out 1: read-data stream. No backpressure.
- `done` out 1: one-cycle pulse when a burst completes normally.
- `err` out 1: one-cycle pulse when a burst is aborted by timeout.
- `wb_cyc`, `wb_stb`, `wb_we` out 1 each.
- `wb_addr` out APP_AW.
- `wb_dati` out dw: data to the slave.
- `wb_sel` out dw/8.
- `wb_cti` out 3.
- `wb_ack` in 1.
- `wb_dato` in dw: data from the slave.

## Operation
States: IDLE, BURST, FINISH.

IDLE
- `cmd_ready`=1.
- On `cmd_valid`: latch `we`, `addr`, `sel` and the beat count (0 becomes 2^LEN_W). Go to BURST.

BURST
- `wb_cyc`=1.
- Read burst: `wb_stb`=1 on every cycle.
- Write burst: `wb_stb`=1 only while the 1-entry write holding register is full.
  - `wb_dati` is that register.
  - `wdat_ready` = !full || (`wb_ack` && `wb_stb`).
  - While the register is empty, `wb_stb`=0 and `wb_cyc` stays 1 (master wait state).
- Each acked beat (`wb_ack` && `wb_stb`):
  - Remaining count decrements.
  - `wb_addr` advances by `dw/8`, modulo 2^APP_AW. Wrap-around is silent.
  - Read bursts: `rdat`<=`wb_dato` and `rdat_valid`=1 on the next cycle. `rdat_last`=1 with the final beat.
- `wb_cti`: 3'b010 while more than one beat remains, 3'b111 on the final beat. A single-beat burst uses 3'b111.
- On the final ack: deassert `wb_cyc` and `wb_stb` on the next cycle and go to FINISH.
- Timeout counter:
  - Cleared on entry to BURST and on every ack.
  - Increments only while `wb_stb`=1 and `wb_ack`=0.
  - On reaching TIMEOUT: deassert `wb_cyc`/`wb_stb` on the next cycle, pulse `err`, go to IDLE. No `done` and no further `rdat_valid`.
  - Write wait states (`wb_stb`=0) never time out.

FINISH
- Pulse `done` for one cycle, then go to IDLE.
- `cmd_ready` is 0 here; it is 1 again in IDLE.

General rules
- `wb_ack` while `wb_stb`=0 is ignored.
- `wdat` accepted while no write burst is active is held in the register and used as the first beat of the next write burst.
- `wb_we`, `wb_sel` and `wb_addr` are stable for the whole beat while `wb_stb`=1.

## Timing
- Reset (`wb_resetn`=0 at a rising edge) takes effect on that edge, including mid-burst. The burst is abandoned with no `done`/`err`.
- Values after reset:
  - 0: `wb_cyc`, `wb_stb`, `wb_we`, `wb_addr`, `wb_dati`, `wb_sel`, `wdat_ready`, `rdat_valid`, `rdat_last`, `rdat`, `done`, `err`.
  - `wb_cti`=3'b000.
  - `cmd_ready`=1, state IDLE, write register empty.
- All bus outputs are registered.
- Read command accepted at edge N: `wb_cyc`/`wb_stb` high from cycle N+1.
- Write command accepted at edge N: `wb_cyc`/`wb_stb` high from cycle N+1 if the register is already full. Otherwise `wb_cyc` is high from N+1 and `wb_stb` goes high the cycle after data is accepted.
- Zero-wait slave (ack every cycle): an L-beat burst holds `wb_stb` for exactly L cycles.
- Final ack at cycle M:
  - `wb_cyc`=0 at M+1.
  - `rdat_valid`/`rdat_last` at M+1.
  - `done` at M+2.
  - `cmd_ready`=1 at M+3.
- Timeout: the ack-less `wb_stb` cycles at which the counter has counted 1 .. TIMEOUT are cycles 1 .. TIMEOUT. `wb_cyc`=0 and `err`=1 both at cycle TIMEOUT+1.

## Test plan
- Read, addr 0x100, len 4, zero-wait slave → `wb_addr` is 0x100, 0x104, 0x108, 0x10C; `wb_cti` is 010, 010, 010, 111; four `rdat_valid` beats with `rdat_last` on the 4th; `done` two cycles after the last ack.
- Write, len 1, `cmd_sel`=4'b0011, data 0xA5A5_0001 presented 3 cycles late → `wb_cyc` is high while `wb_stb` stays low for 3 cycles; then a single beat with `wb_cti`=111, `wb_sel`=0011, `wb_dati`=0xA5A5_0001; then `done`.
- Write, `cmd_len`=0 (16 beats), slave inserts 2 wait states per beat, `wdat_valid` toggled every other cycle → 16 acks, 16 words in order, no beat lost or duplicated.
- Read at addr 2^APP_AW−8, len 4 → `wb_addr` goes 0x3FFFFF8, 0x3FFFFFC, 0x0000000, 0x0000004.
- Slave never acks, TIMEOUT=16 → `wb_stb` high for 16 cycles, then `wb_cyc`=0 and a one-cycle `err`; `done` is never asserted; the next command is accepted and completes normally.
- `wb_resetn` driven low on the 2nd beat of an 8-beat read → bus is idle on the next edge, with no `rdat_valid`, `done` or `err`; after reset releases, `cmd_ready`=1.
